// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core.
// A single FSM steps each instruction through FETCH, DECODE, EXEC, MEM and WB
// around one shared ALU. Instruction and data memories are external and are
// reached through req/ack handshakes that may insert any number of wait states.
// The core also provides halt, fault detection and retire counting.
module mc_cpu #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
  parameter int          DMEM_WORDS = 1024,
  parameter int          RETIRE_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [31:0]         dmem_addr,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_ack,
  input  logic [31:0]         dmem_rdata,
  output logic                halted,
  output logic                fault,
  output logic                retire,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic [31:0]         pc_dbg
);

  localparam logic [31:0] DMEM_BYTES   = 32'(DMEM_WORDS * 4);
  localparam logic [31:0] SYSCALL_WORD = 32'h0000_000C;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t state;

  // Architectural and inter-stage registers
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] imm_ext;
  logic [31:0] br_target;
  logic [31:0] alu_out;
  logic [31:0] mdr;
  logic [31:0] rf [32];

  // Instruction fields
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm16  = ir[15:0];

  // Decoded instruction class
  logic op_rtype_alu;
  logic op_jr;
  logic op_addiu;
  logic op_lw;
  logic op_sw;
  logic op_beq;
  logic op_bne;
  logic op_j;
  logic op_sys;
  logic op_illegal;

  // Datapath helpers
  logic [31:0] sext_imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] alu_res;
  logic [31:0] ea_off;
  logic        ea_bad;
  logic        branch_taken;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        rf_we;

  assign sext_imm    = {{16{imm16[15]}}, imm16};
  assign rs_val      = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rt_val      = (rt == 5'd0) ? 32'd0 : rf[rt];
  assign pc_plus4    = pc + 32'd4;
  assign jump_target = {pc_plus4[31:28], ir[25:0], 2'b00};

  assign imem_addr = pc;
  assign pc_dbg    = pc;

  // Classify the latched instruction; anything outside the subset is illegal
  always_comb begin
    op_rtype_alu = 1'b0;
    op_jr        = 1'b0;
    op_addiu     = 1'b0;
    op_lw        = 1'b0;
    op_sw        = 1'b0;
    op_beq       = 1'b0;
    op_bne       = 1'b0;
    op_j         = 1'b0;
    op_illegal   = 1'b0;
    op_sys       = (ir == SYSCALL_WORD);
    if (!op_sys) begin
      case (opcode)
        OP_RTYPE: begin
          case (funct)
            F_ADDU, F_SUBU, F_AND, F_OR, F_SLT: op_rtype_alu = 1'b1;
            F_JR:                               op_jr        = 1'b1;
            default:                            op_illegal   = 1'b1;
          endcase
        end
        OP_ADDIU: op_addiu   = 1'b1;
        OP_LW:    op_lw      = 1'b1;
        OP_SW:    op_sw      = 1'b1;
        OP_BEQ:   op_beq     = 1'b1;
        OP_BNE:   op_bne     = 1'b1;
        OP_J:     op_j       = 1'b1;
        default:  op_illegal = 1'b1;
      endcase
    end
  end

  // Shared ALU: register-register ops for R-type, rs+imm for everything else
  always_comb begin
    alu_res = a_reg + imm_ext;
    if (opcode == OP_RTYPE) begin
      case (funct)
        F_ADDU:  alu_res = a_reg + b_reg;
        F_SUBU:  alu_res = a_reg - b_reg;
        F_AND:   alu_res = a_reg & b_reg;
        F_OR:    alu_res = a_reg | b_reg;
        F_SLT:   alu_res = ($signed(a_reg) < $signed(b_reg)) ? 32'd1 : 32'd0;
        default: alu_res = a_reg + b_reg;
      endcase
    end
  end

  // Effective-address check and branch condition, both resolved in EXEC
  always_comb begin
    ea_off       = alu_res - DMEM_BASE;
    ea_bad       = (alu_res[1:0] != 2'b00) || (ea_off >= DMEM_BYTES);
    branch_taken = op_beq ? (a_reg == b_reg) : (a_reg != b_reg);
  end

  // Writeback target: rd for R-type, rt for ADDIU/LW; $0 is never written
  always_comb begin
    wb_dst  = (opcode == OP_RTYPE) ? rd : rt;
    wb_data = op_lw ? mdr : alu_out;
    rf_we   = (state == S_WB) && !rst && (wb_dst != 5'd0);
  end

  // Register file has no reset so its contents survive a core reset
  always_ff @(posedge clk) begin
    if (rf_we) begin
      rf[wb_dst] <= wb_data;
    end
  end

  // Main sequencer: one state per phase, all handshake/status outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      halted     <= 1'b0;
      fault      <= 1'b0;
      retire     <= 1'b0;
      retire_cnt <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          // An ack only counts while our request is up, so a stale ack after
          // reset is ignored and the request is raised first.
          if (imem_req && imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end

        S_DECODE: begin
          a_reg     <= rs_val;
          b_reg     <= rt_val;
          imm_ext   <= sext_imm;
          br_target <= pc_plus4 + {sext_imm[29:0], 2'b00};
          state     <= S_EXEC;
        end

        S_EXEC: begin
          if (op_illegal) begin
            halted <= 1'b1;
            fault  <= 1'b1;
            state  <= S_HALT;
          end else if (op_sys) begin
            halted     <= 1'b1;
            retire     <= 1'b1;
            retire_cnt <= retire_cnt + 1'b1;
            state      <= S_HALT;
          end else if (op_beq || op_bne || op_j || op_jr) begin
            if (op_j) begin
              pc <= jump_target;
            end else if (op_jr) begin
              pc <= a_reg;
            end else begin
              pc <= branch_taken ? br_target : pc_plus4;
            end
            retire     <= 1'b1;
            retire_cnt <= retire_cnt + 1'b1;
            imem_req   <= 1'b1;
            state      <= S_FETCH;
          end else if (op_lw || op_sw) begin
            if (ea_bad) begin
              halted <= 1'b1;
              fault  <= 1'b1;
              state  <= S_HALT;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= op_sw;
              dmem_addr  <= ea_off;
              dmem_wdata <= b_reg;
              state      <= S_MEM;
            end
          end else begin
            alu_out <= alu_res;
            state   <= S_WB;
          end
        end

        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              pc         <= pc_plus4;
              retire     <= 1'b1;
              retire_cnt <= retire_cnt + 1'b1;
              imem_req   <= 1'b1;
              state      <= S_FETCH;
            end else begin
              mdr   <= dmem_rdata;
              state <= S_WB;
            end
          end
        end

        S_WB: begin
          pc         <= pc_plus4;
          retire     <= 1'b1;
          retire_cnt <= retire_cnt + 1'b1;
          imem_req   <= 1'b1;
          state      <= S_FETCH;
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          halted <= 1'b1;
          fault  <= 1'b1;
          state  <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: scoreboard bench for mc_cpu.
// An instruction-level reference model runs each program first and queues the
// expected retire and data-memory events; independent monitors pop and compare
// them as the core produces them. Memories answer with random wait states.
module tb_mc_cpu;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam logic [31:0] SYSCALL  = 32'h0000_000C;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        halted;
  logic        fault;
  logic        retire;
  logic [31:0] retire_cnt;
  logic [31:0] pc_dbg;

  mc_cpu #(
    .RESET_PC  (RESET_PC),
    .DMEM_BASE (BASE),
    .DMEM_WORDS(1024),
    .RETIRE_W  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_ack  (dmem_ack),
    .dmem_rdata(dmem_rdata),
    .halted    (halted),
    .fault     (fault),
    .retire    (retire),
    .retire_cnt(retire_cnt),
    .pc_dbg    (pc_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] next_pc; logic [31:0] cnt; int lat; } ret_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } dm_t;

  ret_t ret_q[$];
  dm_t  dm_q[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] prog[256];
  int          plen;
  logic [31:0] iss_regs[32];
  logic [31:0] iss_mem[1024];
  logic [31:0] env_mem[1024];

  int  wait_max  = 0;
  bit  zero_wait = 0;
  bit  imanual   = 0;
  bit  mon_en    = 0;
  int  iwait     = 0;
  int  dwait     = 0;
  int  ret_seen  = 0;

  // Compare one observed value against its expectation and log a failure
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] f);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic emit(input logic [31:0] w);
    prog[plen] = w;
    plen++;
  endtask

  task automatic newProg();
    for (int i = 0; i < 256; i++) prog[i] = SYSCALL;
    plen = 0;
  endtask

  // $4 <- 0x1000_0000 (data base pointer) using only ADDIU and doubling
  task automatic emitBase();
    emit(enc_i(6'h09, 5'd0, 5'd4, 16'h1000));
    for (int i = 0; i < 16; i++) emit(enc_r(5'd4, 5'd4, 5'd4, 6'h21));
  endtask

  // Jump over the following instruction
  task automatic emitJumpSkip();
    logic [31:0] tgt;
    tgt = RESET_PC + 32'((plen + 2) * 4);
    emit({6'h02, tgt[27:2]});
  endtask

  task automatic genDirected();
    int jr_tgt;
    newProg();
    emit(enc_i(6'h09, 5'd0, 5'd1, 16'd5));
    emit(enc_i(6'h09, 5'd1, 5'd2, 16'hFFF9));
    emitBase();
    emit(enc_i(6'h2B, 5'd4, 5'd2, 16'd4));
    emit(enc_i(6'h23, 5'd4, 5'd3, 16'd4));
    emit(enc_i(6'h2B, 5'd4, 5'd3, 16'd8));
    emit(enc_r(5'd2, 5'd1, 5'd5, 6'h2A));
    emit(enc_r(5'd1, 5'd2, 5'd6, 6'h23));
    emit(enc_r(5'd1, 5'd1, 5'd0, 6'h21));
    emit(enc_i(6'h2B, 5'd4, 5'd0, 16'd12));
    emit(enc_i(6'h05, 5'd5, 5'd0, 16'd1));
    emit(enc_i(6'h09, 5'd0, 5'd7, 16'd99));
    emit(enc_i(6'h04, 5'd1, 5'd2, 16'd1));
    emit(enc_i(6'h09, 5'd0, 5'd7, 16'd77));
    emitJumpSkip();
    emit(enc_i(6'h09, 5'd0, 5'd7, 16'd55));
    emit(enc_i(6'h2B, 5'd4, 5'd7, 16'd16));
    emit(enc_i(6'h2B, 5'd4, 5'd5, 16'd20));
    emit(enc_i(6'h2B, 5'd4, 5'd6, 16'd24));
    emit(enc_i(6'h09, 5'd0, 5'd6, 16'h0040));
    for (int i = 0; i < 16; i++) emit(enc_r(5'd6, 5'd6, 5'd6, 6'h21));
    jr_tgt = (plen + 3) * 4;
    emit(enc_i(6'h09, 5'd6, 5'd6, 16'(jr_tgt)));
    emit(enc_r(5'd6, 5'd0, 5'd0, 6'h08));
    emit(enc_i(6'h09, 5'd0, 5'd7, 16'd1));
    emit(enc_i(6'h2B, 5'd4, 5'd7, 16'd28));
    emit(SYSCALL);
  endtask

  task automatic genRandom(input int body);
    logic [5:0] fsel[5];
    logic [4:0] d, s1, s2;
    fsel[0] = 6'h21; fsel[1] = 6'h23; fsel[2] = 6'h24; fsel[3] = 6'h25; fsel[4] = 6'h2A;
    newProg();
    emitBase();
    for (int r = 1; r < 8; r++)
      if (r != 4) emit(enc_i(6'h09, 5'd0, 5'(r), 16'($urandom)));
    for (int k = 0; k < body; k++) begin
      d  = 5'($urandom_range(7));
      if (d == 5'd4) d = 5'd0;
      s1 = 5'($urandom_range(7));
      s2 = 5'($urandom_range(7));
      case ($urandom_range(9))
        0, 1, 2, 3: emit(enc_r(s1, s2, d, fsel[$urandom_range(4)]));
        4, 5:       emit(enc_i(6'h09, s1, d, 16'($urandom)));
        6:          emit(enc_i(6'h2B, 5'd4, s2, 16'($urandom_range(1023) * 4)));
        7:          emit(enc_i(6'h23, 5'd4, d, 16'($urandom_range(1023) * 4)));
        8: begin
          emit(enc_i($urandom_range(1) ? 6'h04 : 6'h05, s1, s2, 16'd1));
          emit(enc_i(6'h09, s1, d, 16'($urandom)));
        end
        default: begin
          emitJumpSkip();
          emit(enc_i(6'h09, s1, d, 16'($urandom)));
        end
      endcase
    end
    for (int r = 1; r < 8; r++) emit(enc_i(6'h2B, 5'd4, 5'(r), 16'((r - 1) * 4)));
    emit(SYSCALL);
  endtask

  task automatic issWr(input logic [4:0] d, input logic [31:0] v);
    if (d != 5'd0) iss_regs[d] = v;
  endtask

  // Instruction-level reference: executes the program and queues expectations
  task automatic runIss(input int limit, output bit eh, output bit ef, output logic [31:0] epc, output int en);
    logic [31:0] pc, w, np, sx, ea, a, b;
    logic [4:0]  rs, rt, rd;
    int          lat, mi;
    bit          bad_i;
    pc = RESET_PC; en = 0; eh = 0; ef = 0;
    while (!eh && en < limit) begin
      w  = prog[int'((pc - RESET_PC) >> 2) & 255];
      rs = w[25:21]; rt = w[20:16]; rd = w[15:11];
      sx = {{16{w[15]}}, w[15:0]};
      a  = iss_regs[rs]; b = iss_regs[rt];
      np = pc + 32'd4; lat = 4; bad_i = 0;
      if (w == SYSCALL) begin
        eh = 1; np = pc; lat = 3;
      end else begin
        case (w[31:26])
          6'h00: case (w[5:0])
            6'h21: issWr(rd, a + b);
            6'h23: issWr(rd, a - b);
            6'h24: issWr(rd, a & b);
            6'h25: issWr(rd, a | b);
            6'h2A: issWr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
            6'h08: begin np = a; lat = 3; end
            default: bad_i = 1;
          endcase
          6'h09: issWr(rt, a + sx);
          6'h23, 6'h2B: begin
            ea = a + sx;
            if (ea[1:0] != 2'b00 || (ea - BASE) >= 32'd4096) bad_i = 1;
            else begin
              mi = int'((ea - BASE) >> 2);
              if (w[31:26] == 6'h2B) begin
                dm_q.push_back('{1'b1, ea - BASE, b});
                iss_mem[mi] = b;
              end else begin
                dm_q.push_back('{1'b0, ea - BASE, 32'd0});
                issWr(rt, iss_mem[mi]);
                lat = 5;
              end
            end
          end
          6'h04: begin lat = 3; if (a == b) np = pc + 32'd4 + (sx << 2); end
          6'h05: begin lat = 3; if (a != b) np = pc + 32'd4 + (sx << 2); end
          6'h02: begin lat = 3; np = {np[31:28], w[25:0], 2'b00}; end
          default: bad_i = 1;
        endcase
      end
      if (bad_i) begin
        eh = 1; ef = 1;
      end else begin
        en++;
        ret_q.push_back('{np, 32'(en), lat});
        if (!eh) pc = np;
      end
    end
    epc = pc;
  endtask

  // Instruction memory responder with random wait states
  always @(negedge clk) begin
    if (!imanual) begin
      if (imem_ack) imem_ack = 1'b0;
      else if (imem_req) begin
        if (iwait == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = prog[int'((imem_addr - RESET_PC) >> 2) & 255];
          iwait      = int'($urandom_range(wait_max));
        end else iwait--;
      end
    end
  end

  // Data memory responder with random wait states
  always @(negedge clk) begin
    if (dmem_ack) dmem_ack = 1'b0;
    else if (dmem_req) begin
      if (dwait == 0) begin
        dmem_ack = 1'b1;
        if (dmem_we) env_mem[int'(dmem_addr >> 2) & 1023] = dmem_wdata;
        else dmem_rdata = env_mem[int'(dmem_addr >> 2) & 1023];
        dwait = int'($urandom_range(wait_max));
      end else dwait--;
    end
  end

  // Monitor: pops expectations when the core retires or starts a data access
  ret_t e_ret;
  dm_t  e_dm;
  int   cyc = 0;
  int   last_cyc = 0;
  bit   last_valid = 0;
  bit   dreq_prev = 0;
  always @(negedge clk) begin
    if (rst) begin
      last_valid = 0;
      dreq_prev  = 0;
    end else if (mon_en) begin
      cyc++;
      if (halted && (imem_req || dmem_req)) begin
        total++; bad++;
        $display("[TB] FAIL req_after_halt: got imem_req=%b dmem_req=%b expected 0", imem_req, dmem_req);
      end
      if (retire) begin
        ret_seen++;
        if (ret_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL extra_retire: got retire at pc %h expected none", pc_dbg);
        end else begin
          e_ret = ret_q.pop_front();
          checkOutput("retire_next_pc", pc_dbg, e_ret.next_pc);
          checkOutput("retire_cnt", retire_cnt, e_ret.cnt);
          if (zero_wait && last_valid) checkOutput("latency", 32'(cyc - last_cyc), 32'(e_ret.lat));
        end
        last_cyc   = cyc;
        last_valid = 1;
      end
      if (dmem_req && !dreq_prev) begin
        if (dm_q.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL extra_dmem_req: got addr %h expected none", dmem_addr);
        end else begin
          e_dm = dm_q.pop_front();
          checkOutput("dmem_we", {31'd0, dmem_we}, {31'd0, e_dm.we});
          checkOutput("dmem_addr", dmem_addr, e_dm.addr);
          if (e_dm.we) checkOutput("dmem_wdata", dmem_wdata, e_dm.wdata);
        end
      end
      dreq_prev = dmem_req;
    end
  end

  task automatic stepMid();
    @(posedge clk);
    #2;
  endtask

  task automatic checkResetState();
    checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("rst_halted", {31'd0, halted}, 32'd0);
    checkOutput("rst_fault", {31'd0, fault}, 32'd0);
    checkOutput("rst_retire", {31'd0, retire}, 32'd0);
    checkOutput("rst_retire_cnt", retire_cnt, 32'd0);
    checkOutput("rst_pc", pc_dbg, RESET_PC);
  endtask

  // Run the core until it halts or reaches the retire limit, then check state
  task automatic waitDone(input int limit, input bit eh, input bit ef, input logic [31:0] epc, input int en);
    int n;
    n = 0;
    while (!halted && ret_seen < limit && n < 20000) begin
      stepMid();
      n++;
    end
    if (n >= 20000) begin
      total++; bad++;
      $display("[TB] FAIL run_timeout: got %0d retires expected %0d", ret_seen, en);
    end
    if (!eh) mon_en = 0;
    repeat (4) stepMid();
    mon_en = 0;
    checkOutput("final_halted", {31'd0, halted}, {31'd0, eh});
    checkOutput("final_pc", pc_dbg, epc);
    checkOutput("pending_retires", 32'(ret_q.size()), 32'd0);
    checkOutput("pending_dmem", 32'(dm_q.size()), 32'd0);
    if (eh) begin
      checkOutput("final_fault", {31'd0, fault}, {31'd0, ef});
      checkOutput("final_retire_cnt", retire_cnt, 32'(en));
    end
  endtask

  // Reset the core, run the reference on the loaded program, then execute it
  task automatic applyStimulus(input int limit, input int wmax);
    bit eh, ef;
    logic [31:0] epc;
    int en;
    imanual = 0; wait_max = wmax; zero_wait = (wmax == 0);
    mon_en = 0; rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; iwait = 0; dwait = 0;
    stepMid();
    stepMid();
    checkResetState();
    ret_q.delete(); dm_q.delete(); ret_seen = 0;
    runIss(limit, eh, ef, epc, en);
    mon_en = 1;
    rst = 1'b0;
    waitDone(limit, eh, ef, epc, en);
  endtask

  task automatic staleAckTest();
    bit eh, ef;
    logic [31:0] epc;
    int en;
    imanual = 1; imem_ack = 1'b0; dmem_ack = 1'b0; mon_en = 0;
    wait_max = 1; zero_wait = 0; rst = 1'b1;
    stepMid();
    stepMid();
    rst = 1'b0;
    stepMid();
    checkOutput("fetch_req_up", {31'd0, imem_req}, 32'd1);
    stepMid();
    checkOutput("fetch_addr_hold", imem_addr, RESET_PC);
    rst = 1'b1;
    stepMid();
    checkOutput("rst_drops_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_reloads_pc", pc_dbg, RESET_PC);
    genRandom(20);
    ret_q.delete(); dm_q.delete(); ret_seen = 0;
    runIss(100000, eh, ef, epc, en);
    rst = 1'b0;
    imem_rdata = 32'hFC00_0000;
    imem_ack = 1'b1;
    mon_en = 1;
    stepMid();
    imem_ack = 1'b0; iwait = 0; imanual = 0;
    waitDone(100000, eh, ef, epc, en);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
    for (int i = 0; i < 32; i++) iss_regs[i] = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      iss_mem[i] = $urandom;
      env_mem[i] = iss_mem[i];
    end

    $display("[TB] directed program, zero wait");
    genDirected();
    applyStimulus(100000, 0);
    $display("[TB] directed program, random wait");
    genDirected();
    applyStimulus(100000, 3);

    for (int t = 0; t < 4; t++) begin
      $display("[TB] random program %0d", t);
      genRandom(30);
      applyStimulus(100000, (t % 2 == 0) ? 0 : 2);
    end

    $display("[TB] branch-to-self loop");
    newProg();
    emit(enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF));
    applyStimulus(10, 0);

    $display("[TB] misaligned load");
    newProg(); emitBase(); emit(enc_i(6'h23, 5'd4, 5'd3, 16'd2));
    applyStimulus(100000, 0);

    $display("[TB] store at last word then past the end");
    newProg(); emitBase();
    emit(enc_i(6'h2B, 5'd4, 5'd4, 16'h0FFC));
    emit(enc_i(6'h2B, 5'd4, 5'd4, 16'h1000));
    applyStimulus(100000, 1);

    $display("[TB] load below base");
    newProg(); emitBase(); emit(enc_i(6'h23, 5'd4, 5'd1, 16'hFFFC));
    applyStimulus(100000, 0);

    $display("[TB] illegal opcode");
    newProg();
    emit(enc_i(6'h09, 5'd0, 5'd1, 16'd3));
    emit(32'hFC00_0000);
    applyStimulus(100000, 0);

    $display("[TB] lone syscall");
    newProg();
    emit(SYSCALL);
    applyStimulus(100000, 0);

    $display("[TB] reset during fetch wait");
    staleAckTest();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
